dist_calc_scheduler: RTL and testbench
======================================

Name: dist_calc_scheduler

Overview:
- Round-robin scheduler that shares one 3-component vector-length engine (three FP32 multipliers, three-input adder, square root) between N requesters. Typical requesters are collision-pair generators.
- Captures one requester's operands, sequences the engine's reset-to-run protocol, and watches for an engine hang with a timeout.
- Returns the FP32 result, tagged with the requester ID, over a valid/ready port.
- Sits between the pair generators and the single shared distance datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must be at least clog2(N_REQ).
- TIMEOUT, 1023, maximum engine cycles in RUN before the job aborts.
- TO_W, 10, timeout counter width.

Ports:
- CLK2  in  1  scheduler clock.
- RST  in  1  reset, asynchronous, active-high.
- req  in  N_REQ  per-requester job request (level).
- a_flat  in  N_REQ*96  per-requester {a3,a2,a1}, FP32 each; requester i occupies bits [96i+95:96i].
- b_flat  in  N_REQ*96  per-requester {b3,b2,b1}, same layout.
- ack  out  N_REQ  one-cycle pulse: operands of the granted requester captured.
- eng_a1, eng_a2, eng_a3, eng_b1, eng_b2, eng_b3  out  32 each  registered operands to the engine.
- eng_rst  out  1  engine reset; low means run.
- eng_done  in  1  engine result-ready level.
- eng_res  in  32  engine FP32 result.
- res  out  32  delivered result.
- res_id  out  ID_W  requester ID for res.
- res_err  out  1  result aborted by timeout; res = 0x7FC00000 (quiet NaN).
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, rr_ptr=0.
  - ack=0, eng_rst=1, all eng_* operands=0.
  - res=0, res_id=0, res_err=0, res_valid=0, busy=0, timeout counter=0.
- Reset mid-job: the job is dropped without any response. Requesters must keep req asserted to be re-served.
- States: IDLE -> GRANT -> SETTLE -> RUN -> DELIVER -> IDLE.
- IDLE:
  - Arbitration is round-robin.
  - Search starts at rr_ptr, wrapping from N_REQ-1 to 0.
  - The first index with req=1 wins.
  - If there is no request, stay in IDLE.
- GRANT (1 cycle):
  - Register the winner's six operands onto eng_*.
  - Pulse ack[winner]=1 for this cycle only.
  - Store the winner ID; set rr_ptr=winner+1 mod N_REQ.
  - Keep eng_rst=1.
- SETTLE (1 cycle): keep eng_rst=1 so the engine sees stable operands under reset.
- RUN:
  - eng_rst=0; operands are held constant; the timeout counter increments each cycle.
  - eng_done=1: capture res=eng_res, res_err=0; go to DELIVER.
  - Counter reaches TIMEOUT with eng_done=0: res=0x7FC00000, res_err=1; go to DELIVER.
  - eng_done=1 on the same cycle as the timeout: eng_done wins (res_err=0).
  - Any eng_done seen outside RUN is ignored.
- DELIVER:
  - On entry: eng_rst=1 again, counter cleared, res_valid=1, res_id=stored ID.
  - res, res_id and res_err are held stable until res_ready=1 with res_valid=1.
  - Transfer cycle: res_valid=0 next cycle; state returns to IDLE.
  - New requests are not granted while in DELIVER (backpressure).
- Latency:
  - req (sampled in IDLE) to ack: 1 cycle.
  - ack to eng_rst fall: 2 cycles.
  - eng_done to res_valid: 1 cycle.
  - Minimum IDLE-to-IDLE job time: 5 cycles plus the engine time.
- Requester protocol:
  - req and operands are held until ack.
  - A requester may drop req before ack. If it is not yet granted this has no effect; once captured in GRANT, the job completes anyway.
- Simultaneous requests: exactly one ack per job; no requester can starve (at most N_REQ-1 jobs ahead of it).
- No arithmetic is performed on the FP32 data; it passes through bit-exact.

Decomposition:
- Package dist_calc_pkg holds:
  - the state encoding (IDLE, GRANT, SETTLE, RUN, DELIVER);
  - the FP32 qNaN constant 32'h7FC00000;
  - the 96-bit vec3 operand slice width.
- One natural sub-module: rr_arbiter (parameter N_REQ). Inputs req and rr_ptr; outputs grant_onehot, grant_id and any_req. Purely combinational, instanced once.

Test Plan:
- Single request: req=0001, a={3.0,0,0}, b={3.0,0,0}, engine model returns 0x40400000 after 20 cycles -> ack[0] 1 cycle after req; res=0x40400000, res_id=0, res_err=0, res_valid held until res_ready.
- All requesting: req=1111 continuously, rr_ptr=0 -> grant order 0,1,2,3,0. Each ack is exactly one cycle wide and never overlaps another.
- Timeout: engine never asserts eng_done, TIMEOUT=1023 -> eng_rst low for exactly 1023 cycles; res=0x7FC00000, res_err=1; the next job proceeds normally.
- Backpressure: res_ready=0 for 50 cycles with req=0110 pending -> res and res_id are stable; no ack occurs until the transfer; next grant goes to ID 2 after ID 1.
- Reset mid-RUN: RST pulsed while RUN is in progress -> all outputs take their reset values asynchronously; the pending requester is re-granted from rr_ptr=0 after RST falls.
- Race: eng_done rises on the same cycle the counter reaches TIMEOUT -> res=eng_res, res_err=0.

Source files
------------

// File: rtl/dist_calc_pkg.sv
// Shared types and constants for the distance-engine scheduler.
package dist_calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SETTLE,
    RUN,
    DELIVER
  } state_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam int unsigned FP32_W    = 32;
  localparam int unsigned VEC3_W    = 3 * FP32_W;

endpackage

// File: rtl/dist_calc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after rr_ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_id,
  output logic             any_req
);

  localparam logic [ID_W:0] N_L = (ID_W+1)'(N_REQ);

  logic [N_REQ-1:0] w_rot;
  logic [ID_W:0]    w_off;
  logic [ID_W:0]    w_sum;
  logic             w_found;

  // Rotating the doubled vector puts rr_ptr at bit 0, so the search is a plain priority pick.
  assign w_rot = N_REQ'({req, req} >> rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (ID_W+1)'(k);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, rr_ptr} + w_off;
    if (w_sum >= N_L) w_sum = w_sum - N_L;
  end

  assign any_req  = |req;
  assign grant_id = w_sum[ID_W-1:0];

  always_comb begin
    grant_onehot = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      grant_onehot[j] = any_req && (w_sum == (ID_W+1)'(j));
    end
  end

endmodule

// File: rtl/dist_calc_scheduler.sv
// Shares one vector-length engine between N_REQ requesters, with timeout and tagged results.
module dist_calc_scheduler
  import dist_calc_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_W    = 10
) (
  input  logic                      CLK2,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*VEC3_W-1:0]   a_flat,
  input  logic [N_REQ*VEC3_W-1:0]   b_flat,
  output logic [N_REQ-1:0]          ack,
  output logic [31:0]               eng_a1,
  output logic [31:0]               eng_a2,
  output logic [31:0]               eng_a3,
  output logic [31:0]               eng_b1,
  output logic [31:0]               eng_b2,
  output logic [31:0]               eng_b3,
  output logic                      eng_rst,
  input  logic                      eng_done,
  input  logic [31:0]               eng_res,
  output logic [31:0]               res,
  output logic [ID_W-1:0]           res_id,
  output logic                      res_err,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy
);

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST  = ID_W'(N_REQ - 1);

  state_t r_state, w_state_nxt;

  logic [N_REQ-1:0]  w_grant_onehot;
  logic [ID_W-1:0]   w_grant_id;
  logic              w_any_req;
  logic [VEC3_W-1:0] w_a_sel, w_b_sel;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_timeout;

  logic [ID_W-1:0]   r_rr_ptr, r_id;
  logic [TO_W-1:0]   r_cnt;
  logic [N_REQ-1:0]  r_ack;
  logic [VEC3_W-1:0] r_eng_a, r_eng_b;
  logic [31:0]       r_res;
  logic [ID_W-1:0]   r_res_id;
  logic              r_res_err, r_res_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req          (req),
    .rr_ptr       (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_id     (w_grant_id),
    .any_req      (w_any_req)
  );

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_grant_onehot[i]) begin
        w_a_sel = w_a_sel | a_flat[i*VEC3_W +: VEC3_W];
        w_b_sel = w_b_sel | b_flat[i*VEC3_W +: VEC3_W];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_id == ID_LAST) ? '0 : w_grant_id + ID_W'(1);
  assign w_timeout = (r_cnt == CNT_LAST);

  always_ff @(posedge CLK2 or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = GRANT;
      GRANT:   w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = RUN;
      RUN:     if (eng_done || w_timeout) w_state_nxt = DELIVER;
      DELIVER: if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands and ack are loaded on the IDLE->GRANT edge so they are visible during GRANT.
  always_ff @(posedge CLK2 or posedge RST) begin
    if (RST) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
      r_res       <= '0;
      r_res_id    <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_ack    <= w_grant_onehot;
            r_id     <= w_grant_id;
            r_rr_ptr <= w_ptr_nxt;
            r_eng_a  <= w_a_sel;
            r_eng_b  <= w_b_sel;
          end
        end
        RUN: begin
          if (eng_done) begin
            r_res       <= eng_res;
            r_res_err   <= 1'b0;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
            r_cnt       <= '0;
          end else if (w_timeout) begin
            r_res       <= FP32_QNAN;
            r_res_err   <= 1'b1;
            r_res_id    <= r_id;
            r_res_valid <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        DELIVER: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign ack       = r_ack;
  assign eng_a1    = r_eng_a[31:0];
  assign eng_a2    = r_eng_a[63:32];
  assign eng_a3    = r_eng_a[95:64];
  assign eng_b1    = r_eng_b[31:0];
  assign eng_b2    = r_eng_b[63:32];
  assign eng_b3    = r_eng_b[95:64];
  assign eng_rst   = (r_state != RUN);
  assign res       = r_res;
  assign res_id    = r_res_id;
  assign res_err   = r_res_err;
  assign res_valid = r_res_valid;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dist_calc_scheduler.sv
// Randomized bench for dist_calc_scheduler with a transaction-level reference model and engine stub.
module tb_dist_calc_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 1023;

  logic         CLK2 = 1'b0;
  logic         RST;
  logic [3:0]   req;
  logic [383:0] a_flat, b_flat;
  logic [3:0]   ack;
  logic [31:0]  eng_a1, eng_a2, eng_a3, eng_b1, eng_b2, eng_b3;
  logic         eng_rst, eng_done;
  logic [31:0]  eng_res, res;
  logic [1:0]   res_id;
  logic         res_err, res_valid, res_ready, busy;
  logic [191:0] eng_ops;

  assign eng_ops = {eng_a3, eng_a2, eng_a1, eng_b3, eng_b2, eng_b1};

  dist_calc_scheduler #(
    .N_REQ   (N),
    .ID_W    (2),
    .TIMEOUT (TIMEOUT),
    .TO_W    (10)
  ) dut (
    .CLK2      (CLK2),
    .RST       (RST),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .ack       (ack),
    .eng_a1    (eng_a1),
    .eng_a2    (eng_a2),
    .eng_a3    (eng_a3),
    .eng_b1    (eng_b1),
    .eng_b2    (eng_b2),
    .eng_b3    (eng_b3),
    .eng_rst   (eng_rst),
    .eng_done  (eng_done),
    .eng_res   (eng_res),
    .res       (res),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 CLK2 = ~CLK2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state (transaction level)
  int           model_ptr, pred_id, cur_id, cur_delay, run_cnt, rst_hi, since_ack, jobs_done;
  bit           job_active, exp_valid, valid_pending, xfer_pending;
  logic [3:0]   pred_ack;
  logic [191:0] pred_ops, cur_ops;
  logic [31:0]  exp_res;
  logic [1:0]   exp_id;
  bit           exp_err;

  // Stimulus policy
  logic [3:0]   mask;
  int           req_pct, drop_pct, ready_pct, delay_mode;
  bit           keep_req;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_ops(input int i);
    a_flat[i*96 +: 96] = {$urandom, $urandom, $urandom};
    b_flat[i*96 +: 96] = {$urandom, $urandom, $urandom};
  endtask

  task automatic raise(input int i);
    if (!req[i]) begin
      req[i] = 1'b1;
      new_ops(i);
    end
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++) begin
      if (req[(model_ptr + k) % N]) return (model_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic predict();
    int w;
    pred_ack = '0;
    if (!job_active) begin
      w = winner();
      if (w >= 0) begin
        pred_ack[w] = 1'b1;
        pred_id     = w;
        pred_ops    = {a_flat[w*96 +: 96], b_flat[w*96 +: 96]};
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK2);
    if (xfer_pending) begin
      exp_valid    = 1'b0;
      job_active   = 1'b0;
      xfer_pending = 1'b0;
      jobs_done++;
    end
    if (valid_pending) begin
      exp_valid     = 1'b1;
      valid_pending = 1'b0;
    end
    check("ack", ack, pred_ack);
    if (pred_ack != 0) begin
      job_active = 1'b1;
      cur_id     = pred_id;
      cur_ops    = pred_ops;
      since_ack  = 0;
      check("grant_ops", eng_ops, pred_ops);
      model_ptr = (pred_id + 1) % N;
      case (delay_mode)
        0:       cur_delay = $urandom_range(40, 1);
        1:       cur_delay = 20;
        2:       cur_delay = 5000;
        default: cur_delay = TIMEOUT;
      endcase
      if (keep_req) new_ops(pred_id);
      else          req[pred_id] = 1'b0;
    end
    if (since_ack == 1) check("rst_hold", eng_rst, 1);
    if (since_ack == 2) check("rst_fall", eng_rst, 0);
    since_ack++;
    check("busy", busy, job_active);
    check("res_valid", res_valid, exp_valid);
    if (exp_valid) check("result", {res_err, res_id, res}, {exp_err, exp_id, exp_res});
    // Engine stub: result after cur_delay run cycles, or silence until the scheduler gives up
    if (!eng_rst) begin
      run_cnt++;
      rst_hi = 0;
      check("run_ops", eng_ops, cur_ops);
      if (run_cnt == cur_delay && cur_delay <= TIMEOUT) begin
        eng_done      = 1'b1;
        eng_res       = $urandom;
        exp_res       = eng_res;
        exp_err       = 1'b0;
        exp_id        = 2'(cur_id);
        valid_pending = 1'b1;
      end else if (run_cnt == TIMEOUT && !eng_done) begin
        exp_res       = 32'h7FC0_0000;
        exp_err       = 1'b1;
        exp_id        = 2'(cur_id);
        valid_pending = 1'b1;
      end
    end else begin
      if (run_cnt != 0) check("run_len", run_cnt, (cur_delay < TIMEOUT) ? cur_delay : TIMEOUT);
      run_cnt = 0;
      rst_hi++;
      if (rst_hi >= 2) eng_done = 1'b0;
    end
    if (!eng_done) eng_res = $urandom;
    res_ready    = ($urandom_range(99, 0) < ready_pct);
    xfer_pending = exp_valid && res_ready;
    for (int i = 0; i < N; i++) begin
      if (req[i] && $urandom_range(99, 0) < drop_pct) req[i] = 1'b0;
      else if (!req[i] && mask[i] && $urandom_range(99, 0) < req_pct) raise(i);
    end
    predict();
  endtask

  task automatic run_jobs(input int n, input int budget);
    int target = jobs_done + n;
    int c = 0;
    while (jobs_done < target && c < budget) begin
      tick();
      c++;
    end
    check("job_budget", jobs_done, target);
  endtask

  task automatic drain();
    int c = 0;
    mask = '0; req_pct = 0; drop_pct = 0; ready_pct = 100;
    req = '0;
    predict();
    while ((job_active || exp_valid) && c < 1500) begin
      tick();
      c++;
    end
    check("drain", job_active, 0);
  endtask

  task automatic reset_checks();
    check("rst_ack", ack, 0);
    check("rst_eng_rst", eng_rst, 1);
    check("rst_ops", eng_ops, 0);
    check("rst_res", {res_err, res_id, res}, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic model_reset();
    model_ptr = 0; job_active = 0; exp_valid = 0; valid_pending = 0; xfer_pending = 0;
    run_cnt = 0; rst_hi = 0; since_ack = 99; pred_ack = '0; eng_done = 1'b0; res_ready = 1'b0;
  endtask

  initial begin
    int c;
    RST = 1'b1; req = '0; a_flat = '0; b_flat = '0; eng_res = '0;
    jobs_done = 0; cur_delay = 0; cur_id = 0; pred_id = 0; cur_ops = '0; pred_ops = '0;
    exp_res = '0; exp_id = '0; exp_err = 1'b0;
    mask = '0; req_pct = 0; drop_pct = 0; ready_pct = 30; delay_mode = 1; keep_req = 1'b0;
    model_reset();
    #3;
    reset_checks();
    @(negedge CLK2);
    #2 RST = 1'b0;

    // Single requester, fixed 20-cycle engine
    req[0] = 1'b1;
    a_flat[95:0] = {32'h0, 32'h0, 32'h4040_0000};
    b_flat[95:0] = {32'h0, 32'h0, 32'h4040_0000};
    predict();
    run_jobs(1, 200);

    // Everyone requesting continuously
    keep_req = 1'b1; delay_mode = 0; ready_pct = 100;
    for (int i = 0; i < N; i++) raise(i);
    predict();
    run_jobs(5, 600);

    // Timeout, then the timeout/done race, then a normal job
    drain();
    keep_req = 1'b0; delay_mode = 2;
    raise(2); predict();
    run_jobs(1, 1200);
    delay_mode = 3;
    raise(1); predict();
    run_jobs(1, 1200);
    delay_mode = 0;
    raise(0); predict();
    run_jobs(1, 200);

    // Backpressure with requesters 1 and 2 pending
    drain();
    keep_req = 1'b1; delay_mode = 1; ready_pct = 0;
    raise(1); raise(2); predict();
    repeat (50) tick();
    ready_pct = 100;
    run_jobs(2, 300);

    // Random traffic
    drain();
    keep_req = 1'b0; mask = 4'b1111; req_pct = 25; drop_pct = 3; ready_pct = 60; delay_mode = 0;
    run_jobs(30, 4000);

    // Reset while RUN is in progress; pointer must restart from 0
    drain();
    keep_req = 1'b1; delay_mode = 2;
    raise(1); predict();
    c = 0;
    while (eng_rst && c < 50) begin
      tick();
      c++;
    end
    check("reach_run", eng_rst, 0);
    raise(3);
    #2 RST = 1'b1;
    #1 reset_checks();
    model_reset();
    @(posedge CLK2);
    #2 RST = 1'b0;
    delay_mode = 0;
    run_jobs(1, 200);

    drain();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
